add_share_arb: RTL and testbench

Round-robin arbiter and sequencer that shares a single W-bit adder between NREQ requesters. Each requester presents a pair of operands and a level request. The block picks one winner per transaction, captures that winner's operands and registers the sum and carry-out. It then returns a one-cycle done pulse to that requester. It sits between the user-facing input capture logic and the adder datapath feeding uo_out.

---
 rtl/add_share_arb_if.sv | 25 ++
 rtl/add_share_arb.sv | 84 ++++++++
 tb/tb_add_share_arb.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/add_share_arb_if.sv
// Bundle of request/operand inputs and grant/result outputs between the
// requesters and the shared-adder arbiter.
interface add_share_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [W-1:0]      sum;
  logic              carry;
  logic              busy;

  modport master (
    output req, op_a, op_b,
    input  gnt, done, sum, carry, busy
  );

  modport slave (
    input  req, op_a, op_b,
    output gnt, done, sum, carry, busy
  );
endinterface

// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one W-bit adder among NREQ requesters:
// grant captures the winner's operands, the next cycle registers sum/carry and pulses done.
module add_share_arb #(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  add_share_arb_if.slave  bus
);
  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE, EXEC} state_e;

  state_e          state_q;
  logic [IW-1:0]   last_q;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic            carry_q;
  logic [NREQ-1:0] gnt_q, done_q;

  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand_idx;
  logic            win_found;
  logic [W-1:0]    a_sel, b_sel;

  // Search starts one past the last winner, so a just-served requester goes to the back.
  // NOTE: every signal assigned in always_comb gets a default first; otherwise a latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    cand_idx  = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = IW'((int'(last_q) + k) % NREQ);
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign a_sel = bus.op_a[int'(win_idx)*W +: W];
  assign b_sel = bus.op_b[int'(win_idx)*W +: W];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the operand registers are plain flops, not a memory array, so they are cleared on reset too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= IW'(NREQ - 1);
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (win_found) begin
            a_q     <= a_sel;
            b_q     <= b_sel;
            gnt_q   <= NREQ'(1) << win_idx;
            last_q  <= win_idx;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          {carry_q, sum_q} <= {1'b0, a_q} + {1'b0, b_q};
          done_q  <= gnt_q;
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.carry = carry_q;
  assign bus.busy  = (state_q == EXEC);
endmodule

// File: tb/tb_add_share_arb.sv
// Self-checking bench for add_share_arb: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a transaction-level model.
module tb_add_share_arb;
  localparam int NREQ = 4;
  localparam int W    = 8;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  add_share_arb_if #(.NREQ(NREQ), .W(W)) bus ();

  add_share_arb #(.NREQ(NREQ), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_op(input int who, input logic [7:0] a, input logic [7:0] b);
    bus.op_a[who*W +: W] = a;
    bus.op_b[who*W +: W] = b;
  endtask

  // Leaves the bench just after a negedge, before the next rising edge.
  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Transaction-level reference: one transaction is either in flight or not,
  // and its result is plain integer addition of the captured operands.
  int          m_last;
  bit          m_inflight;
  int          m_win;
  int          m_a, m_b;
  logic [3:0]  m_gnt, m_done;
  int          m_sum, m_carry;

  task automatic model_reset();
    m_last = NREQ - 1;
    m_inflight = 0;
    m_win = 0; m_a = 0; m_b = 0;
    m_gnt = '0; m_done = '0;
    m_sum = 0; m_carry = 0;
  endtask

  // Applies what the DUT will see at the coming rising edge.
  task automatic model_step();
    if (m_inflight) begin
      m_sum      = (m_a + m_b) % 256;
      m_carry    = (m_a + m_b) / 256;
      m_done     = 4'(1 << m_win);
      m_gnt      = '0;
      m_inflight = 0;
    end else begin
      m_done = '0;
      m_gnt  = '0;
      for (int d = 1; d <= NREQ; d++) begin
        int i;
        i = (m_last + d) % NREQ;
        if (!m_inflight && bus.req[i]) begin
          m_win      = i;
          m_a        = int'(bus.op_a[i*W +: W]);
          m_b        = int'(bus.op_b[i*W +: W]);
          m_last     = i;
          m_gnt      = 4'(1 << i);
          m_inflight = 1;
        end
      end
    end
  endtask

  typedef struct {
    int         who;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       carry;
  } vec_t;

  vec_t vecs[6];

  initial begin
    errors = 0;
    checks = 0;

    vecs[0] = '{who: 0, a: 8'h12, b: 8'h34, sum: 8'h46, carry: 1'b0};
    vecs[1] = '{who: 1, a: 8'hFF, b: 8'h01, sum: 8'h00, carry: 1'b1};
    vecs[2] = '{who: 2, a: 8'h80, b: 8'h80, sum: 8'h00, carry: 1'b1};
    vecs[3] = '{who: 3, a: 8'hFF, b: 8'hFF, sum: 8'hFE, carry: 1'b1};
    vecs[4] = '{who: 0, a: 8'h7F, b: 8'h80, sum: 8'hFF, carry: 1'b0};
    vecs[5] = '{who: 2, a: 8'h00, b: 8'h00, sum: 8'h00, carry: 1'b0};

    rst_n    = 1'b0;
    bus.req  = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    #1;
    check("reset_gnt",   32'(bus.gnt),   32'h0);
    check("reset_done",  32'(bus.done),  32'h0);
    check("reset_sum",   32'(bus.sum),   32'h0);
    check("reset_carry", 32'(bus.carry), 32'h0);
    check("reset_busy",  32'(bus.busy),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a transaction.
    reset_pulse();
    bus.req = 4'b1111;
    set_op(0, 8'h21, 8'h43); set_op(1, 8'h05, 8'h06);
    set_op(2, 8'h07, 8'h08); set_op(3, 8'h09, 8'h0A);
    @(negedge clk);
    check("rst_seq_gnt0", 32'(bus.gnt), 32'h1);
    @(negedge clk);
    check("rst_seq_sum0", 32'(bus.sum), 32'h64);
    @(negedge clk);
    check("rst_seq_gnt1", 32'(bus.gnt), 32'h2);
    check("rst_seq_busy", 32'(bus.busy), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_gnt",   32'(bus.gnt),   32'h0);
    check("midrst_done",  32'(bus.done),  32'h0);
    check("midrst_sum",   32'(bus.sum),   32'h0);
    check("midrst_carry", 32'(bus.carry), 32'h0);
    check("midrst_busy",  32'(bus.busy),  32'h0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_gnt", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    @(negedge clk);
    check("post_rst_done", 32'(bus.done), 32'h1);
    check("post_rst_sum",  32'(bus.sum),  32'h64);

    // Directed single-requester vectors, including the overflow cases.
    for (int v = 0; v < 6; v++) begin
      set_op(vecs[v].who, vecs[v].a, vecs[v].b);
      bus.req = 4'(1 << vecs[v].who);
      @(negedge clk);
      check("vec_gnt",  32'(bus.gnt),  32'(1 << vecs[v].who));
      check("vec_busy", 32'(bus.busy), 32'h1);
      check("vec_done_low", 32'(bus.done), 32'h0);
      bus.req = '0;
      @(negedge clk);
      check("vec_done",  32'(bus.done),  32'(1 << vecs[v].who));
      check("vec_sum",   32'(bus.sum),   32'(vecs[v].sum));
      check("vec_carry", 32'(bus.carry), 32'(vecs[v].carry));
      check("vec_gnt_low", 32'(bus.gnt), 32'h0);
      if (v == 0) begin
        for (int c = 0; c < 10; c++) begin
          bus.op_a = 32'($urandom);
          bus.op_b = 32'($urandom);
          @(negedge clk);
          check("hold_sum",  32'(bus.sum),  32'h46);
          check("hold_done", 32'(bus.done), 32'h0);
        end
      end
    end

    // Fairness: all four requesting for 16 cycles.
    reset_pulse();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(8'h10*i + 3), 8'(8'h21 + i));
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_gnt",  32'(bus.gnt),  32'(1 << (k % 4)));
      check("rr_busy", 32'(bus.busy), 32'h1);
      @(negedge clk);
      check("rr_done", 32'(bus.done), 32'(1 << (k % 4)));
      check("rr_sum",  32'(bus.sum),  32'((16*(k % 4) + 3 + 33 + (k % 4)) % 256));
    end
    bus.req = '0;

    // Pointer wrap: after requester 2, 4'b1010 goes 3 then 1.
    reset_pulse();
    set_op(2, 8'h01, 8'h02);
    bus.req = 4'b0100;
    @(negedge clk);
    check("wrap_gnt2", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    @(negedge clk);
    check("wrap_done2", 32'(bus.done), 32'h4);
    set_op(1, 8'h11, 8'h11);
    set_op(3, 8'h33, 8'h33);
    bus.req = 4'b1010;
    @(negedge clk);
    check("wrap_gnt3", 32'(bus.gnt), 32'h8);
    bus.req = 4'b0010;
    @(negedge clk);
    check("wrap_sum3", 32'(bus.sum), 32'h66);
    @(negedge clk);
    check("wrap_gnt1", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    @(negedge clk);
    check("wrap_sum1", 32'(bus.sum), 32'h22);

    // Back-to-back from requester 1 with operands changed after each grant.
    reset_pulse();
    set_op(1, 8'h01, 8'h01);
    bus.req = 4'b0010;
    @(negedge clk);
    check("b2b_gnt_a", 32'(bus.gnt), 32'h2);
    set_op(1, 8'h10, 8'h20);
    @(negedge clk);
    check("b2b_done_a", 32'(bus.done), 32'h2);
    check("b2b_sum_a",  32'(bus.sum),  32'h02);
    @(negedge clk);
    check("b2b_gnt_b", 32'(bus.gnt), 32'h2);
    check("b2b_done_gap", 32'(bus.done), 32'h0);
    bus.req = '0;
    @(negedge clk);
    check("b2b_done_b", 32'(bus.done), 32'h2);
    check("b2b_sum_b",  32'(bus.sum),  32'h30);

    // Randomized traffic against the reference model.
    reset_pulse();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      bus.req  = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      bus.op_a = 32'($urandom);
      bus.op_b = 32'($urandom);
      model_step();
      @(negedge clk);
      check("rand_gnt",   32'(bus.gnt),   32'(m_gnt));
      check("rand_done",  32'(bus.done),  32'(m_done));
      check("rand_sum",   32'(bus.sum),   32'(m_sum));
      check("rand_carry", 32'(bus.carry), 32'(m_carry));
      check("rand_busy",  32'(bus.busy),  32'(m_gnt != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
